int_ctrl: RTL and testbench
===========================

# int_ctrl

Memory-mapped interrupt controller between the peripheral interrupt lines (timer `int_sig_o` on source 0, other peripherals on higher sources) and the core's interrupt entry logic. It captures requests into pending bits and selects the highest-priority enabled source. It presents that source to the core with a req/ack handshake and blocks the source from re-pending until software writes completion. Registers are accessed over the same simple bus as the other peripherals: `addr_i`/`data_i`/`we_i` in, combinational `data_o` out.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..31.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `irq_i`  in  NUM_SRC  interrupt lines, active-high; bit 0 is the timer.
- `addr_i`  in  32  bus address; only `[3:0]` is decoded.
- `data_i`  in  32  bus write data.
- `we_i`  in  1  bus write enable, active-high.
- `data_o`  out  32  bus read data, combinational from `addr_i`.
- `int_req_o`  out  1  interrupt request to core, registered.
- `int_id_o`  out  5  ID of the requested source (source n gives ID n+1); 0 means none. Registered.
- `int_ack_i`  in  1  core accepts the request; sampled only while `int_req_o`=1.

## Operation
- Registers:
  - 0x0 ENABLE, rw, bits `[NUM_SRC-1:0]`.
  - 0x4 PENDING, read-only; writes are ignored.
  - 0x8 CLAIM: read returns the in-service ID, or 0 when none. A write of the matching ID completes service.
  - 0xC CTRL, rw: bit0 is global enable; other bits read 0.
  - Unmapped offsets read 0.
- Gateway, level mode:
  - `pending[n]` is set at an edge where `irq_i[n]`=1 and source n is not in service.
  - `pending[n]` clears only when source n is acknowledged.
  - A pending bit is never cleared by `irq_i` falling.
- Priority is fixed: the lowest index among `pending & ENABLE` wins. Candidates exist only when CTRL.bit0=1.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE → REQ when a candidate exists. The winner's ID is latched into `int_id_o` and `int_req_o` is set to 1.
  - REQ → SERVICE on `int_ack_i`=1. The latched source's pending bit is cleared, the in-service ID is set to the latched ID, `int_req_o` goes to 0 and `int_id_o` goes to 0.
  - REQ → IDLE when the latched source's ENABLE bit or CTRL.bit0 goes to 0 without an ack. Its pending bit is retained.
  - SERVICE → IDLE on a bus write to 0x8 whose `data_i[4:0]` equals the in-service ID. The in-service ID is cleared. A mismatched write is ignored.
- While in REQ, `int_id_o` stays stable; a higher-priority arrival does not preempt.
- Nesting is not supported: no new request is raised in SERVICE.
- Same-edge events:
  - An ack and `irq_i` of the same source at one edge: pending clears. Re-pending is blocked until completion.
  - A complete write while `irq_i` is still high: the source re-pends on the next edge.
  - A bus write to ENABLE or CTRL takes effect for FSM decisions from the next edge.

## Timing
- Reset values:
  - `int_req_o`=0, `int_id_o`=0.
  - ENABLE, PENDING and CTRL are 0; the in-service ID is 0; the FSM is in IDLE.
  - `data_o`=0 while `rst`=1.
- Latency, with `irq_i` rising before edge N: PENDING is set after N, and `int_req_o`=1 after N+1.
- Ack sampled at edge M: `int_req_o`=0 after M; CLAIM reads the ID from M+1.
- A complete write at edge K returns the FSM to IDLE after K. The next request can assert after K+1.
- `data_o` is purely combinational, with zero-cycle read latency.

## Configuration
- `INT_CTRL_EDGE_EN` defined: each source has an `irq_i` delay register.
  - `pending[n]` is set on a 0→1 transition of `irq_i[n]`, even while the source is in service.
  - A held-high line does not re-pend after completion.
- Not defined: level behaviour as in Operation; no delay registers are built.

## Test plan
- Timer request: ENABLE=0x1, CTRL=0x1, then pulse `irq_i[0]` high for 1 cycle → PENDING=0x1, then `int_req_o`=1 with `int_id_o`=1. Ack → CLAIM reads 1 and PENDING reads 0. Write 1 to 0x8 → FSM returns to IDLE.
- Priority: ENABLE=0xFF, CTRL=1, assert `irq_i`=0x0C in the same cycle → `int_id_o`=3 first. After ack and complete of ID 3 → `int_id_o`=4.
- Withdrawal: ENABLE=0x2, CTRL=1, `irq_i[1]` high, FSM in REQ, write ENABLE=0 → `int_req_o`=0 next cycle and PENDING=0x2 retained.
- Complete mismatch: in SERVICE with ID 2, write 5 to 0x8 → CLAIM still reads 2 and no request is raised. Write 2 → FSM returns to IDLE.
- Level re-pend: hold `irq_i[0]`=1 through the complete write → PENDING=0x1 one edge later and a new request follows. With `INT_CTRL_EDGE_EN` defined → no re-pend.
- Reset mid-REQ: assert `rst` for 1 cycle → `int_req_o`=0, `int_id_o`=0, and all registers read 0.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller with a fixed-priority gateway
// and a req/ack/complete handshake to the core.
//
// Register map (addr_i[3:0]):
//   0x0 ENABLE   rw  per-source enable
//   0x4 PENDING  ro  captured requests
//   0x8 CLAIM    read in-service ID, write matching ID to complete service
//   0xC CTRL     rw  bit0 global enable
//
// Build option: define INT_CTRL_EDGE_EN to capture requests on rising edges
// of irq_i instead of level. The default (undefined) build is level mode.
//
// FSM states:
//   state      | meaning
//   ST_IDLE    | no request outstanding, nothing in service
//   ST_REQ     | int_req_o high, waiting for the core to ack
//   ST_SERVICE | source acked, waiting for the complete write to CLAIM

module int_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    input  logic               we_i,
    output logic [31:0]        data_o,
    output logic               int_req_o,
    output logic [4:0]         int_id_o,
    input  logic               int_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] OFS_ENABLE  = 4'h0;
    localparam logic [3:0] OFS_PENDING = 4'h4;
    localparam logic [3:0] OFS_CLAIM   = 4'h8;
    localparam logic [3:0] OFS_CTRL    = 4'hC;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               ctrl_q, ctrl_d;
    logic [4:0]         svc_id_q, svc_id_d;
    logic               req_q, req_d;
    logic [4:0]         id_q, id_d;

    logic               wr_enable;
    logic               wr_ctrl;
    logic               wr_claim;
    logic               complete;
    logic               ack_take;
    logic               withdraw;
    logic [NUM_SRC-1:0] cand_vec;
    logic               cand_any;
    logic [4:0]         win_id;
    logic [NUM_SRC-1:0] lat_mask;
    logic [NUM_SRC-1:0] set_vec;
    logic               unused_bus;

    // Only addr_i[3:0] and a few data_i bits are meaningful
    assign unused_bus = ^{addr_i, data_i};

    // Bus write decode
    always_comb begin
        wr_enable = we_i && (addr_i[3:0] == OFS_ENABLE);
        wr_ctrl   = we_i && (addr_i[3:0] == OFS_CTRL);
        wr_claim  = we_i && (addr_i[3:0] == OFS_CLAIM);
        complete  = wr_claim && (state_q == ST_SERVICE) && (data_i[4:0] == svc_id_q);
    end

    // Candidate vector and lowest-index winner
    always_comb begin
        cand_vec = ctrl_q ? (pending_q & enable_q) : '0;
        cand_any = |cand_vec;
        win_id   = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand_vec[i]) begin
                win_id = 5'(i + 1);
            end
        end
    end

    // One-hot mask of the source currently latched in int_id_o
    always_comb begin
        lat_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            lat_mask[i] = (id_q == 5'(i + 1));
        end
    end

    // Handshake events seen while a request is outstanding
    always_comb begin
        ack_take = (state_q == ST_REQ) && int_ack_i;
        withdraw = (state_q == ST_REQ) && !int_ack_i &&
                   (!ctrl_q || !(|(lat_mask & enable_q)));
    end

`ifdef INT_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] irq_dly_q;

    // Delayed copy of irq_i for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_dly_q <= '0;
        end else begin
            irq_dly_q <= irq_i;
        end
    end

    // A rising edge pends even while the source is in service
    assign set_vec = irq_i & ~irq_dly_q;
`else
    logic [NUM_SRC-1:0] svc_mask;

    // One-hot mask of the in-service source; it may not re-pend until completed
    always_comb begin
        svc_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            svc_mask[i] = (svc_id_q == 5'(i + 1));
        end
    end

    assign set_vec = irq_i & ~svc_mask;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ack wins over a same-edge withdrawal
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cand_any) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_take) begin
                    state_d = ST_SERVICE;
                end else if (withdraw) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (complete) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        req_d = (state_d == ST_REQ);

        if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
            id_d = win_id;
        end else if (state_d == ST_REQ) begin
            id_d = id_q;
        end else begin
            id_d = 5'd0;
        end

        svc_id_d = svc_id_q;
        if (ack_take) begin
            svc_id_d = id_q;
        end else if (complete) begin
            svc_id_d = 5'd0;
        end

        // Ack clears even if the same source is asserting at this edge
        pending_d = pending_q | set_vec;
        if (ack_take) begin
            pending_d = pending_d & ~lat_mask;
        end

        enable_d = wr_enable ? data_i[NUM_SRC-1:0] : enable_q;
        ctrl_d   = wr_ctrl ? data_i[0] : ctrl_q;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q  <= '0;
            pending_q <= '0;
            ctrl_q    <= 1'b0;
            svc_id_q  <= 5'd0;
            req_q     <= 1'b0;
            id_q      <= 5'd0;
        end else begin
            enable_q  <= enable_d;
            pending_q <= pending_d;
            ctrl_q    <= ctrl_d;
            svc_id_q  <= svc_id_d;
            req_q     <= req_d;
            id_q      <= id_d;
        end
    end

    assign int_req_o = req_q;
    assign int_id_o  = id_q;

    // Combinational read mux, forced to zero during reset
    always_comb begin
        data_o = 32'd0;
        if (!rst) begin
            case (addr_i[3:0])
                OFS_ENABLE:  data_o[NUM_SRC-1:0] = enable_q;
                OFS_PENDING: data_o[NUM_SRC-1:0] = pending_q;
                OFS_CLAIM:   data_o[4:0]         = svc_id_q;
                OFS_CTRL:    data_o[0]           = ctrl_q;
                default:     data_o              = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Testbench for int_ctrl: directed scenarios plus randomized traffic checked
// against a behavioural model of the controller.

module tb_int_ctrl;

    localparam int NUM = 8;

    logic            clk;
    logic            rst;
    logic [NUM-1:0]  irq;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic            we;
    logic [31:0]     rdata;
    logic            int_req;
    logic [4:0]      int_id;
    logic            ack;

    int errors = 0;
    int checks = 0;

`ifdef INT_CTRL_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    int_ctrl #(.NUM_SRC(NUM)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_i     (irq),
        .addr_i    (addr),
        .data_i    (wdata),
        .we_i      (we),
        .data_o    (rdata),
        .int_req_o (int_req),
        .int_id_o  (int_id),
        .int_ack_i (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what software and the core would observe
    bit [NUM-1:0] m_en;
    bit [NUM-1:0] m_pend;
    bit           m_ctrl;
    int           m_svc;
    bit           m_req;
    int           m_id;
    bit [NUM-1:0] m_prev;

    function automatic void model_step();
        bit [NUM-1:0] n_en   = m_en;
        bit [NUM-1:0] n_pend = m_pend;
        bit           n_ctrl = m_ctrl;
        int           n_svc  = m_svc;
        bit           n_req  = m_req;
        int           n_id   = m_id;
        int           winner = -1;
        if (rst) begin
            m_en = '0; m_pend = '0; m_ctrl = 0; m_svc = 0;
            m_req = 0; m_id = 0; m_prev = '0;
            return;
        end
        for (int n = 0; n < NUM; n++) begin
            if (EDGE_MODE) begin
                if (irq[n] && !m_prev[n]) n_pend[n] = 1'b1;
            end else begin
                if (irq[n] && (m_svc != n + 1)) n_pend[n] = 1'b1;
            end
        end
        if (m_req) begin
            if (ack) begin
                n_pend[m_id-1] = 1'b0;
                n_svc = m_id;
                n_req = 0;
                n_id  = 0;
            end else if (!m_ctrl || !m_en[m_id-1]) begin
                n_req = 0;
                n_id  = 0;
            end
        end else if (m_svc != 0) begin
            if (we && addr[3:0] == 4'h8 && int'(wdata[4:0]) == m_svc) n_svc = 0;
        end else if (m_ctrl) begin
            for (int n = NUM - 1; n >= 0; n--) begin
                if (m_pend[n] && m_en[n]) winner = n;
            end
            if (winner >= 0) begin
                n_req = 1;
                n_id  = winner + 1;
            end
        end
        if (we && addr[3:0] == 4'h0) n_en = wdata[NUM-1:0];
        if (we && addr[3:0] == 4'hC) n_ctrl = wdata[0];
        m_en = n_en; m_pend = n_pend; m_ctrl = n_ctrl; m_svc = n_svc;
        m_req = n_req; m_id = n_id; m_prev = irq;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (rst) return 32'd0;
        case (a[3:0])
            4'h0:    return 32'(m_en);
            4'h4:    return 32'(m_pend);
            4'h8:    return 32'(m_svc);
            4'hC:    return 32'(m_ctrl);
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic do_reset();
        irq = '0; ack = 1'b0; we = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        irq = '0; ack = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        rst = 1'b1;
        tick(); tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", int_req); end
        checks++; if (int_id !== 5'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", int_id); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_data_o_in_rst got=%h exp=0", rdata); end
        rst = 1'b0;
        tick();
        for (int r = 0; r < 4; r++) begin
            addr = 32'(r * 4);
            #1;
            checks++;
            if (rdata !== 32'd0) begin errors++; $display("FAIL reset_reg_%0h got=%h exp=0", addr, rdata); end
        end
    endtask

    task automatic test_timer();
        bus_write(32'h0, 32'h1);
        bus_write(32'hC, 32'h1);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        addr = 32'h4; #1;
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL timer_pending got=%h exp=1", rdata); end
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL timer_req_early got=%0b exp=0", int_req); end
        tick();
        checks++; if (int_req !== 1'b1 || int_id !== 5'd1) begin errors++; $display("FAIL timer_req got=%0b/%0d exp=1/1", int_req, int_id); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++; if (int_req !== 1'b0 || int_id !== 5'd0) begin errors++; $display("FAIL timer_ack_drop got=%0b/%0d exp=0/0", int_req, int_id); end
        tick();
        addr = 32'h8; #1;
        checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL timer_claim got=%h exp=1", rdata); end
        addr = 32'h4; #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL timer_pending_clr got=%h exp=0", rdata); end
        bus_write(32'h8, 32'd1);
        addr = 32'h8; #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL timer_complete got=%h exp=0", rdata); end
        tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL timer_idle_req got=%0b exp=0", int_req); end
    endtask

    task automatic test_priority();
        bus_write(32'h0, 32'hFF);
        irq = 8'h0C;
        tick();
        irq = 8'h00;
        tick();
        checks++; if (int_req !== 1'b1 || int_id !== 5'd3) begin errors++; $display("FAIL prio_first got=%0b/%0d exp=1/3", int_req, int_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        bus_write(32'h8, 32'd3);
        tick();
        checks++; if (int_req !== 1'b1 || int_id !== 5'd4) begin errors++; $display("FAIL prio_second got=%0b/%0d exp=1/4", int_req, int_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        bus_write(32'h8, 32'd4);
    endtask

    task automatic test_withdraw();
        do_reset();
        bus_write(32'h0, 32'h2);
        bus_write(32'hC, 32'h1);
        irq = 8'h02;
        tick(); tick();
        checks++; if (int_req !== 1'b1 || int_id !== 5'd2) begin errors++; $display("FAIL wd_req got=%0b/%0d exp=1/2", int_req, int_id); end
        bus_write(32'h0, 32'h0);
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL wd_same_edge got=%0b exp=1", int_req); end
        tick();
        checks++; if (int_req !== 1'b0 || int_id !== 5'd0) begin errors++; $display("FAIL wd_drop got=%0b/%0d exp=0/0", int_req, int_id); end
        addr = 32'h4; #1;
        checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL wd_pending got=%h exp=2", rdata); end
        irq = 8'h00;
    endtask

    task automatic test_mismatch();
        do_reset();
        bus_write(32'h0, 32'h2);
        bus_write(32'hC, 32'h1);
        irq = 8'h02; tick(); irq = 8'h00; tick();
        ack = 1'b1; tick(); ack = 1'b0;
        bus_write(32'h8, 32'd5);
        addr = 32'h8; #1;
        checks++; if (rdata !== 32'd2) begin errors++; $display("FAIL mm_claim got=%h exp=2", rdata); end
        tick(); tick();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL mm_no_req got=%0b exp=0", int_req); end
        bus_write(32'h8, 32'd2);
        addr = 32'h8; #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mm_complete got=%h exp=0", rdata); end
    endtask

    task automatic test_level_repend();
        logic [31:0] exp_p;
        logic        exp_r;
        do_reset();
        bus_write(32'h0, 32'h1);
        bus_write(32'hC, 32'h1);
        irq = 8'h01;
        tick(); tick();
        checks++; if (int_req !== 1'b1 || int_id !== 5'd1) begin errors++; $display("FAIL lr_req got=%0b/%0d exp=1/1", int_req, int_id); end
        ack = 1'b1; tick(); ack = 1'b0;
        addr = 32'h4; #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL lr_ack_clear got=%h exp=0", rdata); end
        tick();
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL lr_blocked got=%h exp=0", rdata); end
        bus_write(32'h8, 32'd1);
        addr = 32'h4; #1;
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL lr_at_complete got=%h exp=0", rdata); end
        exp_p = EDGE_MODE ? 32'd0 : 32'd1;
        exp_r = EDGE_MODE ? 1'b0 : 1'b1;
        tick();
        checks++; if (rdata !== exp_p) begin errors++; $display("FAIL lr_repend got=%h exp=%h", rdata, exp_p); end
        tick();
        checks++; if (int_req !== exp_r) begin errors++; $display("FAIL lr_rereq got=%0b exp=%0b", int_req, exp_r); end
        irq = 8'h00;
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        bus_write(32'h0, 32'h1);
        bus_write(32'hC, 32'h1);
        irq = 8'h01; tick(); irq = 8'h00; tick();
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL rmr_setup got=%0b exp=1", int_req); end
        rst = 1'b1;
        addr = 32'h0;
        tick();
        checks++; if (int_req !== 1'b0 || int_id !== 5'd0) begin errors++; $display("FAIL rmr_out got=%0b/%0d exp=0/0", int_req, int_id); end
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            addr = 32'(r * 4);
            #1;
            checks++;
            if (rdata !== 32'd0) begin errors++; $display("FAIL rmr_reg_%0h got=%h exp=0", addr, rdata); end
        end
    endtask

    task automatic test_random();
        logic [31:0] hi;
        logic [31:0] exp_d;
        int          sel;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            irq = ($urandom_range(0, 2) == 0) ? NUM'($urandom & $urandom) : '0;
            ack = ($urandom_range(0, 2) == 0);
            we  = ($urandom_range(0, 3) == 0);
            hi  = $urandom;
            sel = $urandom_range(0, 4);
            case (sel)
                0: begin addr = {hi[31:4], 4'h0}; wdata = $urandom; end
                1: begin addr = {hi[31:4], 4'h4}; wdata = $urandom; end
                2: begin addr = {hi[31:4], 4'h8}; wdata = $urandom_range(0, 9); end
                3: begin addr = {hi[31:4], 4'hC}; wdata = $urandom; wdata[0] = ($urandom_range(0, 3) != 0); end
                default: begin addr = hi; wdata = $urandom; end
            endcase
            #1;
            exp_d = model_read(addr);
            checks++;
            if (rdata !== exp_d) begin errors++; $display("FAIL rand_read cyc=%0d addr=%h got=%h exp=%h", c, addr, rdata, exp_d); end
            tick();
            checks++;
            if (int_req !== m_req || int_id !== 5'(m_id)) begin
                errors++;
                $display("FAIL rand_out cyc=%0d got=%0b/%0d exp=%0b/%0d", c, int_req, int_id, m_req, m_id);
            end
        end
        rst = 1'b0; we = 1'b0; ack = 1'b0; irq = '0;
    endtask

    initial begin
        test_reset();
        test_timer();
        test_priority();
        test_withdraw();
        test_mismatch();
        test_level_repend();
        test_reset_mid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
